// File: rtl/reg_enc_pkg.sv
// Shared types and helpers for the register request encoder.
// Optional round-robin selection is enabled with REG_ENC_ROUND_ROBIN_EN.
package reg_enc_pkg;

  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;

  typedef logic [IDX_W-1:0]    reg_idx_t;
  typedef logic [NUM_REGS-1:0] reg_vec_t;

  function automatic reg_vec_t onehot(input reg_idx_t i);
    return reg_vec_t'(1) << i;
  endfunction

endpackage

// File: rtl/reg_request_encoder_rr_priority_select.sv
// Combinational search for the first set bit of vec, starting at start and wrapping.
// With start tied to zero this is a plain lowest-index priority encoder.
module rr_priority_select
  import reg_enc_pkg::*;
(
  input  reg_vec_t vec,
  input  reg_idx_t start,
  output logic     found,
  output reg_idx_t idx
);

  // Walk from the farthest offset back to start so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (vec[start + reg_idx_t'(i)]) begin
        found = 1'b1;
        idx   = start + reg_idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/reg_request_encoder.sv
// Latches sticky per-register requests and serialises them as a 4-bit index stream.
// Define REG_ENC_ROUND_ROBIN_EN for rotating selection; default is lowest index first.
module reg_request_encoder
  import reg_enc_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     clear_i,
  input  reg_vec_t req_i,
  input  logic     ready_i,
  output logic     valid_o,
  output reg_idx_t idx_o,
  output reg_vec_t pending_o,
  output logic     dup_o
);

  reg_vec_t pending;
  logic     valid_q;
  reg_idx_t idx_q;
  logic     dup_q;

  logic     hs;
  logic     load;
  reg_vec_t consume;
  reg_vec_t pending_next;
  logic     dup_next;
  reg_idx_t start;
  logic     sel_found;
  reg_idx_t sel_idx;

  assign hs           = valid_q & ready_i;
  assign load         = ~valid_q | hs;
  assign consume      = hs ? onehot(idx_q) : '0;
  // A re-request of the index being consumed lands back in pending here.
  assign pending_next = (pending & ~consume) | req_i;
  assign dup_next     = |(req_i & pending & ~consume);

`ifdef REG_ENC_ROUND_ROBIN_EN
  reg_idx_t ptr;

  assign start = ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clear_i) begin
      ptr <= '0;
    end else if (load && sel_found) begin
      ptr <= sel_idx + reg_idx_t'(1);
    end
  end
`else
  assign start = '0;
`endif

  rr_priority_select u_sel (
    .vec   (pending_next),
    .start (start),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      dup_q   <= 1'b0;
    end else if (clear_i) begin
      pending <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      dup_q   <= 1'b0;
    end else begin
      pending <= pending_next;
      dup_q   <= dup_next;
      if (load) begin
        valid_q <= sel_found;
        idx_q   <= sel_idx;
      end
    end
  end

  assign valid_o   = valid_q;
  assign idx_o     = idx_q;
  assign pending_o = pending;
  assign dup_o     = dup_q;

endmodule

// File: doc/reg_request_encoder.md
Name: reg_request_encoder

Overview:
- Inverse companion of the register-bank write-enable decoder: collects 16 per-register request lines and converts them into a 4-bit register index stream.
- Pending requests are latched sticky; one index is presented at a time on a valid/ready handshake.
- Sits between per-register event sources (writeback, interrupt-style flags) and the register-bank address port, serialising multi-hot requests into single addresses.

Parameters:
- NUM_REGS, 16, number of request lines; fixed at 16 in this revision.
- IDX_W, 4, index width; equals log2(NUM_REGS).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear_i  input  1  synchronous flush of all pending requests and the current grant.
- req_i  input  16  request pulses; bit k requests register k; multi-hot allowed.
- ready_i  input  1  consumer accepts idx_o this cycle when valid_o=1.
- valid_o  output  1  idx_o holds a granted request.
- idx_o  output  4  granted register index.
- pending_o  output  16  current pending vector, including the granted bit.
- dup_o  output  1  one-cycle pulse: a req_i bit arrived while that bit was already pending.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: valid_o=0, idx_o=0, pending_o=0, dup_o=0, round-robin pointer=0.
- State:
  - pending[15:0].
  - grant register (valid_q, idx_q).
  - ptr[3:0], used only with the optional feature.
- Handshake (hs) = valid_o & ready_i.
- Pending update per edge:
  - pending_next = (pending & ~(hs ? onehot(idx_q) : 0)) | req_i.
  - A re-request of the index being consumed in the same cycle stays pending.
- Grant load:
  - Condition: !valid_q or hs.
  - Candidate set = pending_next.
  - valid_q <= |candidate; idx_q <= selected index.
- Grant hold: while valid_q & !ready_i, idx_q and valid_q are held stable, regardless of new arrivals.
- Latency:
  - req_i asserted in cycle t with the block idle -> valid_o=1 with that index in cycle t+1.
  - After hs in cycle t, the next grant is visible in cycle t+1; back-to-back throughput is 1 index per cycle.
- Selection, default: fixed priority, lowest index first.
- dup_o = |(req_i & pending & ~(hs ? onehot(idx_q) : 0)), registered, so it appears one cycle after the arrival. Duplicate requests merge; no count is kept.
- clear_i:
  - Takes priority over req_i and hs in the same cycle.
  - pending <= 0, valid_q <= 0, ptr <= 0, dup_o <= 0.
  - A req_i pulse coinciding with clear_i is dropped.
- Reset mid-operation: all state is zeroed immediately; there is no partial grant afterwards.
- All 16 pending: indices are drained in selection order, 16 handshakes, no loss.
- ready_i with valid_o=0: ignored.

Optional Feature:
- Macro: REG_ENC_ROUND_ROBIN_EN.
- Defined:
  - Selection searches from ptr upward, wrapping 15 -> 0.
  - On each grant load, ptr <= selected index + 1 (mod 16).
- Undefined: fixed lowest-index priority; the ptr register is omitted.

Decomposition:
- Package reg_enc_pkg:
  - NUM_REGS=16, IDX_W=4.
  - typedef reg_idx_t (logic [3:0]), typedef reg_vec_t (logic [15:0]).
- Sub-module rr_priority_select:
  - Combinational.
  - Inputs: vec (16), start (4).
  - Outputs: found, idx.
  - With start tied to 0 it provides the fixed-priority mode.

Test Plan:
- Reset, then req_i=16'h0000 for 5 cycles -> valid_o=0, pending_o=0, dup_o=0 throughout.
- req_i=16'h8421 pulse for one cycle, ready_i=1 -> idx_o sequence 0,5,10,15 on consecutive cycles, then valid_o=0. With REG_ENC_ROUND_ROBIN_EN the same order applies from ptr=0.
- Grant idx 3 with ready_i=0 for 4 cycles while req_i=16'h0001 arrives -> idx_o stays 3, valid_o=1. Then ready_i=1 -> next idx_o=0.
- Bit 6 pending with req_i bit 6 pulsed again -> dup_o=1 for exactly one cycle and a single grant of 6. Re-pulse bit 6 in the handshake cycle of 6 -> 6 is granted again the next cycle.
- req_i=16'hFFFF with clear_i=1 in the same cycle -> pending_o=0, valid_o=0. Assert rst mid-drain of 16'h00F0 -> all outputs 0 immediately, no grants after release.
- REG_ENC_ROUND_ROBIN_EN: bits 2 and 9 held re-requesting on every handshake -> grants alternate 2,9,2,9; fixed mode instead yields 2,2,2.
